// File: rtl/memq_id_alloc_pkg.sv
// memq_id_alloc_pkg: shared types, default depths and queue-id helper functions
package memq_id_alloc_pkg;
  localparam int DEF_LDQ_DEPTH = 16;
  localparam int DEF_STQ_DEPTH = 16;
  localparam int LDQ_IDW = $clog2(DEF_LDQ_DEPTH) + 1;
  localparam int STQ_IDW = $clog2(DEF_STQ_DEPTH) + 1;
  typedef logic [LDQ_IDW-1:0] t_ldq_id;
  typedef logic [STQ_IDW-1:0] t_stq_id;
  typedef struct packed {
    logic       valid;
    logic [6:0] robid;
  } t_nuke_pkt;
  function automatic logic [31:0] qid_inc(input logic [31:0] id, input int unsigned depth);
    return (id + 32'd1) & (32'(depth) * 32'd2 - 32'd1);
  endfunction
  function automatic logic [31:0] qid_occ(input logic [31:0] tail, input logic [31:0] head);
    return tail - head;
  endfunction
endpackage

// File: rtl/memq_id_alloc_if.sv
// memq_id_alloc_if: dispatch, retire, drain and nuke signals plus allocated ids and queue flags
interface memq_id_alloc_if
  import memq_id_alloc_pkg::*;
#(
  parameter int LDQ_DEPTH = DEF_LDQ_DEPTH,
  parameter int STQ_DEPTH = DEF_STQ_DEPTH
);
  t_nuke_pkt                      nuke_rb1;
  logic                           disp_valid_rs0;
  logic                           disp_is_ld_rs0;
  logic                           disp_is_st_rs0;
  logic                           ld_retire_rb1;
  logic                           st_retire_rb1;
  logic                           st_drain_mm;
  logic [$clog2(LDQ_DEPTH):0]     ldqid_alloc_rs0;
  logic [$clog2(STQ_DEPTH):0]     stqid_alloc_rs0;
  logic                           ldq_full;
  logic                           stq_full;
  logic                           ldq_empty;
  logic                           stq_empty;
  modport master (
    output nuke_rb1, disp_valid_rs0, disp_is_ld_rs0, disp_is_st_rs0,
    output ld_retire_rb1, st_retire_rb1, st_drain_mm,
    input  ldqid_alloc_rs0, stqid_alloc_rs0, ldq_full, stq_full, ldq_empty, stq_empty
  );
  modport slave (
    input  nuke_rb1, disp_valid_rs0, disp_is_ld_rs0, disp_is_st_rs0,
    input  ld_retire_rb1, st_retire_rb1, st_drain_mm,
    output ldqid_alloc_rs0, stqid_alloc_rs0, ldq_full, stq_full, ldq_empty, stq_empty
  );
endinterface

// File: rtl/memq_id_alloc_qid_ptr.sv
// qid_ptr: wrap-tagged circular queue pointer with increment, load and sync reset
module qid_ptr
  import memq_id_alloc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);
  // load (rewind) takes priority over increment
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else q <= load ? load_val : inc ? W'(qid_inc(32'(q), DEPTH)) : q;
endmodule

// File: rtl/memq_id_alloc.sv
// memq_id_alloc: LDQ/STQ id allocation, free tracking, full/empty flags and nuke rewind
module memq_id_alloc
  import memq_id_alloc_pkg::*;
#(
  parameter int LDQ_DEPTH = DEF_LDQ_DEPTH,
  parameter int STQ_DEPTH = DEF_STQ_DEPTH
) (
  input logic              clk,
  input logic              reset,
  memq_id_alloc_if.slave   io
);
  localparam int LW = $clog2(LDQ_DEPTH) + 1;
  localparam int SW = $clog2(STQ_DEPTH) + 1;
  logic [LW-1:0] ld_head, ld_tail, ld_head_nxt, ld_occ;
  logic [SW-1:0] st_head, st_cmt, st_tail, st_cmt_nxt, st_occ;
  logic nuke, ld_alloc, st_alloc;
  // nuke rewinds tails to the post-retire head/commit point, so same-cycle retires count
  always_comb begin
    nuke = io.nuke_rb1.valid;
    ld_alloc = io.disp_valid_rs0 & io.disp_is_ld_rs0 & ~nuke;
    st_alloc = io.disp_valid_rs0 & io.disp_is_st_rs0 & ~nuke;
    ld_head_nxt = io.ld_retire_rb1 ? LW'(qid_inc(32'(ld_head), LDQ_DEPTH)) : ld_head;
    st_cmt_nxt = io.st_retire_rb1 ? SW'(qid_inc(32'(st_cmt), STQ_DEPTH)) : st_cmt;
    ld_occ = LW'(qid_occ(32'(ld_tail), 32'(ld_head)));
    st_occ = SW'(qid_occ(32'(st_tail), 32'(st_head)));
  end
  qid_ptr #(.DEPTH(LDQ_DEPTH)) u_ld_head (
    .clk(clk), .reset(reset), .inc(io.ld_retire_rb1), .load(1'b0), .load_val('0), .q(ld_head)
  );
  qid_ptr #(.DEPTH(LDQ_DEPTH)) u_ld_tail (
    .clk(clk), .reset(reset), .inc(ld_alloc), .load(nuke), .load_val(ld_head_nxt), .q(ld_tail)
  );
  qid_ptr #(.DEPTH(STQ_DEPTH)) u_st_head (
    .clk(clk), .reset(reset), .inc(io.st_drain_mm), .load(1'b0), .load_val('0), .q(st_head)
  );
  qid_ptr #(.DEPTH(STQ_DEPTH)) u_st_cmt (
    .clk(clk), .reset(reset), .inc(io.st_retire_rb1), .load(1'b0), .load_val('0), .q(st_cmt)
  );
  qid_ptr #(.DEPTH(STQ_DEPTH)) u_st_tail (
    .clk(clk), .reset(reset), .inc(st_alloc), .load(nuke), .load_val(st_cmt_nxt), .q(st_tail)
  );
  assign io.ldqid_alloc_rs0 = ld_tail;
  assign io.stqid_alloc_rs0 = st_tail;
  assign io.ldq_full = ld_occ == LW'(LDQ_DEPTH);
  assign io.stq_full = st_occ == SW'(STQ_DEPTH);
  assign io.ldq_empty = ld_occ == '0;
  assign io.stq_empty = st_occ == '0;
  // protocol checks: overflow without a same-cycle free, and frees from empty regions
  always_ff @(posedge clk)
    if (!reset) begin
      assert (!(ld_alloc && io.ldq_full && !io.ld_retire_rb1));
      assert (!(st_alloc && io.stq_full && !io.st_drain_mm));
      assert (!(io.ld_retire_rb1 && ld_head == ld_tail));
      assert (!(io.st_retire_rb1 && st_cmt == st_tail));
      assert (!(io.st_drain_mm && st_head == st_cmt));
    end
endmodule

// File: tb/tb_memq_id_alloc.sv
// tb_memq_id_alloc: directed table and sequence checks for the LDQ/STQ id allocator
module tb_memq_id_alloc;
  import memq_id_alloc_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  memq_id_alloc_if bus ();
  memq_id_alloc dut (.clk(clk), .reset(reset), .io(bus));
  typedef struct {
    logic dv, ld, st, lr, sr, dr, nk;
    logic [4:0] e_ldq, e_stq;
    logic e_lfull, e_sfull, e_lempty, e_sempty;
  } vec_t;
  vec_t tbl[20];
  task automatic go(input logic dv, ld, st, lr, sr, dr, nk);
    @(negedge clk);
    bus.disp_valid_rs0 = dv;
    bus.disp_is_ld_rs0 = ld;
    bus.disp_is_st_rs0 = st;
    bus.ld_retire_rb1 = lr;
    bus.st_retire_rb1 = sr;
    bus.st_drain_mm = dr;
    bus.nuke_rb1.valid = nk;
    bus.nuke_rb1.robid = '0;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    go(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 0, 0, 1, 1};
    for (int i = 0; i < 16; i++)
      tbl[1+i] = '{1, 1, 0, 0, 0, 0, 0, 5'(i), 5'h00, 0, 0, (i == 0), 1};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 5'h10, 5'h00, 1, 0, 0, 1};
    tbl[18] = '{1, 1, 0, 1, 0, 0, 0, 5'h10, 5'h00, 1, 0, 0, 1};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 5'h11, 5'h00, 1, 0, 0, 1};
    go(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      go(tbl[i].dv, tbl[i].ld, tbl[i].st, tbl[i].lr, tbl[i].sr, tbl[i].dr, tbl[i].nk);
      chk($sformatf("tbl%0d ldqid", i), 32'(bus.ldqid_alloc_rs0), 32'(tbl[i].e_ldq));
      chk($sformatf("tbl%0d stqid", i), 32'(bus.stqid_alloc_rs0), 32'(tbl[i].e_stq));
      chk($sformatf("tbl%0d ldq_full", i), 32'(bus.ldq_full), 32'(tbl[i].e_lfull));
      chk($sformatf("tbl%0d stq_full", i), 32'(bus.stq_full), 32'(tbl[i].e_sfull));
      chk($sformatf("tbl%0d ldq_empty", i), 32'(bus.ldq_empty), 32'(tbl[i].e_lempty));
      chk($sformatf("tbl%0d stq_empty", i), 32'(bus.stq_empty), 32'(tbl[i].e_sempty));
    end
    chk("ld_head after full retire", 32'(dut.ld_head), 32'h01);
    for (int k = 0; k < 16; k++) begin
      go(0, 0, 0, 1, 0, 0, 0);
      chk($sformatf("drain%0d ldq_full", k), 32'(bus.ldq_full), 32'(k == 0));
      chk($sformatf("drain%0d ldq_empty", k), 32'(bus.ldq_empty), 32'd0);
    end
    go(0, 0, 0, 0, 0, 0, 0);
    chk("drained ldq_empty", 32'(bus.ldq_empty), 32'd1);
    chk("drained ldqid", 32'(bus.ldqid_alloc_rs0), 32'h11);
    do_reset();
    go(1, 1, 0, 0, 0, 0, 0);
    chk("wrap0 ldqid", 32'(bus.ldqid_alloc_rs0), 32'h00);
    for (int k = 1; k < 40; k++) begin
      go(1, 1, 0, 1, 0, 0, 0);
      chk($sformatf("wrap%0d ldqid", k), 32'(bus.ldqid_alloc_rs0), 32'(k % 32));
      chk($sformatf("wrap%0d occ1", k), 32'({bus.ldq_empty, bus.ldq_full}), 32'd0);
    end
    go(0, 0, 0, 0, 0, 0, 0);
    chk("wrap end ldqid", 32'(bus.ldqid_alloc_rs0), 32'h08);
    chk("wrap end occ1", 32'({bus.ldq_empty, bus.ldq_full}), 32'd0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      go(1, 0, 1, 0, 0, 0, 0);
      chk($sformatf("st%0d stqid", i), 32'(bus.stqid_alloc_rs0), 32'(i));
    end
    repeat (2) go(0, 0, 0, 0, 1, 0, 0);
    go(0, 0, 0, 0, 1, 0, 1);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("st nuke stqid", 32'(bus.stqid_alloc_rs0), 32'h03);
    chk("st nuke st_cmt", 32'(dut.st_cmt), 32'h03);
    chk("st nuke stq_empty", 32'(bus.stq_empty), 32'd0);
    chk("st nuke ldqid", 32'(bus.ldqid_alloc_rs0), 32'h00);
    for (int i = 0; i < 3; i++) begin
      go(0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("st drain%0d empty", i), 32'(bus.stq_empty), 32'd0);
    end
    go(0, 0, 0, 0, 0, 0, 0);
    chk("st drained empty", 32'(bus.stq_empty), 32'd1);
    chk("st drained stqid", 32'(bus.stqid_alloc_rs0), 32'h03);
    do_reset();
    go(1, 1, 0, 0, 0, 0, 0);
    go(1, 1, 0, 1, 0, 0, 1);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("ld nuke ldqid", 32'(bus.ldqid_alloc_rs0), 32'h01);
    chk("ld nuke ld_head", 32'(dut.ld_head), 32'h01);
    chk("ld nuke ldq_empty", 32'(bus.ldq_empty), 32'd1);
    do_reset();
    for (int i = 0; i < 16; i++) go(1, 0, 1, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("stq full flag", 32'(bus.stq_full), 32'd1);
    chk("stq full stqid", 32'(bus.stqid_alloc_rs0), 32'h10);
    chk("stq full empty", 32'(bus.stq_empty), 32'd0);
    do_reset();
    for (int i = 0; i < 7; i++) go(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) go(1, 1, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0, 1);
    chk("pre-reset ldqid", 32'(bus.ldqid_alloc_rs0), 32'd10);
    chk("pre-reset stqid", 32'(bus.stqid_alloc_rs0), 32'd7);
    reset = 1'b1;
    go(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("rst ldqid", 32'(bus.ldqid_alloc_rs0), 32'd0);
    chk("rst stqid", 32'(bus.stqid_alloc_rs0), 32'd0);
    chk("rst empties", 32'({bus.ldq_empty, bus.stq_empty}), 32'd3);
    chk("rst fulls", 32'({bus.ldq_full, bus.stq_full}), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
